// File: rtl/bhg_fifo_arbiter.sv
// rtl/bhg_fifo_arbiter.sv - round-robin burst arbiter draining FWFT FIFOs into one downstream FIFO.
// Define BHG_FIFO_ARB_PRIORITY_EN to give requester 0 absolute priority and preemption.
module bhg_fifo_arbiter #(
  parameter  int bits      = 8,
  parameter  int ports     = 4,
  parameter  int max_burst = 4,
  localparam int PB        = (ports > 1) ? $clog2(ports) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ports-1:0]      req_ready,
  input  logic [ports*bits-1:0] req_data,
  output logic [ports-1:0]      req_shift,
  input  logic                  out_full,
  output logic                  out_shift,
  output logic [bits-1:0]       out_data,
  output logic [PB-1:0]         out_port,
  output logic                  busy
);

  localparam int CB = $clog2(max_burst + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state_q, state_d;
  logic [PB-1:0] grant_q, grant_d;
  logic [PB-1:0] last_q, last_d;
  logic [CB-1:0] bcnt_q, bcnt_d;

  logic [PB-1:0] rr_pick;
  logic          rr_found;
  logic [PB-1:0] pick;
  logic          preempt;

  // First ready requester strictly after the last one served, wrapping.
  always_comb begin
    rr_pick  = '0;
    rr_found = 1'b0;
    for (int i = 1; i <= ports; i++) begin
      if (!rr_found && req_ready[(int'(last_q) + i) % ports]) begin
        rr_pick  = PB'((int'(last_q) + i) % ports);
        rr_found = 1'b1;
      end
    end
  end

`ifdef BHG_FIFO_ARB_PRIORITY_EN
  assign pick    = req_ready[0] ? '0 : rr_pick;
  assign preempt = (grant_q != '0) && req_ready[0];
`else
  assign pick    = rr_pick;
  assign preempt = 1'b0;
`endif

  assign out_data = req_data[int'(grant_q)*bits +: bits];
  assign out_port = grant_q;
  assign busy     = (state_q == GRANT);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    bcnt_d    = bcnt_q;
    out_shift = 1'b0;
    req_shift = '0;
    case (state_q)
      IDLE: begin
        if (|req_ready) begin
          grant_d = pick;
          bcnt_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // A stall (ready but downstream full) leaves count and state untouched.
        out_shift          = req_ready[grant_q] && !out_full && !reset;
        req_shift[grant_q] = out_shift;
        if (out_shift) begin
          bcnt_d = CB'(bcnt_q + 1'b1);
        end
        if (!req_ready[grant_q] || preempt ||
            (out_shift && (bcnt_q == CB'(max_burst - 1)))) begin
          last_d  = grant_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= PB'(ports - 1);
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      bcnt_q  <= bcnt_d;
    end
  end

endmodule

// File: tb/tb_bhg_fifo_arbiter.sv
// tb/tb_bhg_fifo_arbiter.sv - directed bench for bhg_fifo_arbiter (default build, 4 ports, burst 4).
module tb_bhg_fifo_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req_ready;
  logic [31:0] req_data;
  logic [3:0]  req_shift;
  logic        out_full = 1'b0;
  logic        out_shift;
  logic [7:0]  out_data;
  logic [1:0]  out_port;
  logic        busy;

  int cnt[4];
  int taken[4];
  int vectors = 0;
  int miscompares = 0;

  bhg_fifo_arbiter #(.bits(8), .ports(4), .max_burst(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_shift (req_shift),
    .out_full  (out_full),
    .out_shift (out_shift),
    .out_data  (out_data),
    .out_port  (out_port),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation ran past its time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Source FIFOs: word k of port p carries p*16+k.
  task automatic drive();
    for (int p = 0; p < 4; p++) begin
      req_ready[p]        = (cnt[p] > 0);
      req_data[p*8 +: 8]  = 8'(p*16 + taken[p]);
    end
  endtask

  // exp: -1 idle, -2 granted but no transfer, p>=0 transfer from port p.
  task automatic cycle(input string tag, input int exp);
    logic [3:0] exp_rs;
    logic [3:0] rs;
    drive();
    @(negedge clk);
    exp_rs = (exp >= 0) ? 4'(1 << exp) : 4'b0000;
    chk({tag, "/out_shift"}, 32'(out_shift), 32'(exp >= 0));
    chk({tag, "/req_shift"}, 32'(req_shift), 32'(exp_rs));
    chk({tag, "/busy"}, 32'(busy), 32'(exp != -1));
    if (exp >= 0) begin
      chk({tag, "/out_port"}, 32'(out_port), 32'(exp));
      chk({tag, "/out_data"}, 32'(out_data), 32'(exp*16 + taken[exp]));
    end
    rs = req_shift;
    @(posedge clk);
    #1;
    for (int p = 0; p < 4; p++) begin
      if (rs[p] && cnt[p] > 0) begin
        cnt[p]--;
        taken[p]++;
      end
    end
    drive();
  endtask

  task automatic do_reset(input int c0, input int c1, input int c2, input int c3);
    cnt[0] = c0; cnt[1] = c1; cnt[2] = c2; cnt[3] = c3;
    for (int p = 0; p < 4; p++) taken[p] = 0;
    reset    = 1'b1;
    out_full = 1'b0;
    drive();
    @(posedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst/out_shift", 32'(out_shift), 32'd0);
    chk("rst/req_shift", 32'(req_shift), 32'd0);
    chk("rst/busy", 32'(busy), 32'd0);
    chk("rst/out_port", 32'(out_port), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive();
  endtask

  int s2[] = '{-1, 2, 2, 2, -2, -1};
  int s3[] = '{-1, 1, 1, -2, -2, -2, -2, -2, 1, 1, -1, 1, 1};
  int s4[] = '{-1, 1, 1, 1, 1, -1, 3, -2, -1, 1};
  int s5[] = '{-1, 2, 2, 2, 2, -1, 3, 3};

  initial begin
    req_ready = '0;
    req_data  = '0;

    // All four ready: 0,1,2,3,0 with four words each and one idle cycle between.
    do_reset(8, 8, 8, 8);
    for (int c = 0; c < 25; c++)
      cycle($sformatf("rr_c%0d", c), (c % 5 == 0) ? -1 : (c / 5) % 4);

    // Only port 2 with three words: ends when its ready drops.
    do_reset(0, 0, 3, 0);
    for (int c = 0; c < s2.size(); c++)
      cycle($sformatf("short_c%0d", c), s2[c]);
    chk("short/taken2", 32'(taken[2]), 32'd3);

    // Downstream full for five cycles mid-burst on port 1.
    do_reset(0, 6, 0, 0);
    for (int c = 0; c < s3.size(); c++) begin
      out_full = (c >= 3 && c <= 7);
      cycle($sformatf("stall_c%0d", c), s3[c]);
    end
    out_full = 1'b0;
    chk("stall/taken1", 32'(taken[1]), 32'd6);

    // Reset on the second word of a port-3 burst; arbitration restarts from port 0.
    do_reset(0, 4, 0, 8);
    for (int c = 0; c < s4.size(); c++) begin
      reset = (c == 7);
      if (c == 8) begin
        cnt[1] = 4;
        cnt[2] = 4;
      end
      cycle($sformatf("midrst_c%0d", c), s4[c]);
    end
    reset = 1'b0;
    chk("midrst/taken3", 32'(taken[3]), 32'd1);

    // Port 0 rises during a port-2 burst: no preemption in the default build.
    do_reset(0, 0, 8, 8);
    for (int c = 0; c < s5.size(); c++) begin
      if (c == 2) cnt[0] = 4;
      cycle($sformatf("prio_c%0d", c), s5[c]);
    end
    chk("prio/taken0", 32'(taken[0]), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bhg_fifo_arbiter.md
BHG_FIFO_ARBITER -- requirements
Module: bhg_fifo_arbiter

Interface
REQ-001 The block SHALL have parameter bits, default 8, the data word width.
REQ-002 The block SHALL have parameter ports, default 4, the number of requesters (2..16).
REQ-003 The block SHALL have parameter max_burst, default 4, the maximum number of words per grant (1..256).
REQ-004 The block SHALL have localparam PB = max(1, $clog2(ports)).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port req_ready, input, [ports-1:0]: per-requester FWFT data_ready.
REQ-008 The block SHALL have port req_data, input, [ports*bits-1:0]: packed FWFT data_out; port p occupies bits [p*bits +: bits].
REQ-009 The block SHALL have port req_shift, output, [ports-1:0]: per-requester shift_out pulse.
REQ-010 The block SHALL have port out_full, input, 1 bit: downstream FIFO full.
REQ-011 The block SHALL have port out_shift, output, 1 bit: downstream shift_in.
REQ-012 The block SHALL have port out_data, output, [bits-1:0]: downstream data_in.
REQ-013 The block SHALL have port out_port, output, [PB-1:0]: index of the granted requester.
REQ-014 The block SHALL have port busy, output, 1 bit: high while in state GRANT.

Function
REQ-015 The block SHALL have exactly two states, IDLE and GRANT, plus registers grant[PB], last[PB] and bcnt[$clog2(max_burst+1)].
REQ-016 IDLE: when any req_ready bit is high, the block SHALL load grant with the first p having req_ready[p]=1, searching last+1, last+2, ... modulo ports; it SHALL clear bcnt and enter GRANT on the next edge.
REQ-017 IDLE: out_shift and all req_shift bits SHALL be 0.
REQ-018 GRANT: out_shift SHALL equal req_ready[grant] && !out_full, combinationally.
REQ-019 GRANT: req_shift[grant] SHALL equal out_shift; every other req_shift bit SHALL be 0.
REQ-020 out_data SHALL always equal req_data slice grant, and out_port SHALL always equal grant.
REQ-021 GRANT: on each cycle with out_shift=1, bcnt SHALL increment.
REQ-022 GRANT with req_ready[grant]=1 and out_full=1 SHALL stall: no transfer, no count, state held.
REQ-023 GRANT SHALL exit to IDLE, with last<=grant, when out_shift=1 and bcnt==max_burst-1, or when req_ready[grant]=0.
REQ-024 Latency SHALL be 1 cycle from req_ready rising in IDLE to the first possible out_shift; re-arbitration between grants SHALL cost 1 IDLE cycle.
REQ-025 At most one word SHALL transfer per cycle; no word SHALL be duplicated or dropped.
REQ-026 With max_burst=1, exactly one word SHALL transfer per grant.
REQ-027 Requesters not granted SHALL retain their data untouched.

Reset
REQ-028 While reset=1, out_shift and req_shift SHALL be 0.
REQ-029 On reset the block SHALL set state=IDLE, grant=0, last=ports-1, bcnt=0, busy=0 and out_port=0, so port 0 has first priority after reset.
REQ-030 Reset asserted mid-burst SHALL abort the grant at that edge; the next arbitration SHALL start from last=ports-1.

Configuration
REQ-031 With macro BHG_FIFO_ARB_PRIORITY_EN defined, in IDLE req_ready[0]=1 SHALL win regardless of last.
REQ-032 With BHG_FIFO_ARB_PRIORITY_EN defined, in GRANT with grant!=0 and req_ready[0]=1, the block SHALL exit to IDLE after the current cycle, any transfer in that cycle still completing.
REQ-033 Without BHG_FIFO_ARB_PRIORITY_EN, arbitration SHALL be pure round-robin per REQ-016 and REQ-023.

Verification
REQ-034 Reset, then req_ready=4'b1111, out_full=0, max_burst=4 -> ports granted 0,1,2,3,0 with 4 words each and 1 idle cycle between grants.
REQ-035 Only port 2 ready with 3 words, max_burst=4 -> 3 out_shift pulses with out_port=2, then IDLE when req_ready[2] drops.
REQ-036 Port 1 granted, out_full=1 for 5 cycles mid-burst -> no out_shift, bcnt frozen, burst resumes and totals 4 words.
REQ-037 Reset asserted on the 2nd word of a port-3 burst -> req_shift=0 that cycle; the next grant goes to the lowest ready port starting from 0.
REQ-038 With BHG_FIFO_ARB_PRIORITY_EN defined, port 2 bursting and req_ready[0] rising -> port 2 ends after the current cycle and port 0 is granted next; without the macro, port 2 completes 4 words and port 3 is granted next if ready.
